// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two masters.
// Registers the winning command and routes read data back with a valid pulse.
module dmem_arbiter #(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16,
    parameter int unsigned MAXBURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] a0,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic          rv0,
    output logic          rv1,
    output logic          men,
    output logic          rw,
    output logic [AW-1:0] da,
    output logic [DW-1:0] dout,
    input  logic [DW-1:0] din
);

    localparam int unsigned BW = $clog2(MAXBURST + 1);
    localparam logic [BW:0] MAXB = (BW + 1)'(MAXBURST);

    logic          pri;
    logic          own;
    logic [BW-1:0] bcnt;
    logic          mid;
    logic          pend_v;
    logic          pend_id;

    logic          acc;
    logic          sel;
    logic          sel_rw;
    logic          sel_lock;
    logic [AW-1:0] sel_a;
    logic [DW-1:0] sel_wd;
    logic [BW-1:0] bcnt_base;
    logic [BW:0]   bcnt_inc;

    always_comb begin
        gnt0      = req0 & (~req1 | ~pri);
        gnt1      = req1 & (~req0 | pri);
        acc       = (req0 & gnt0) | (req1 & gnt1);
        sel       = req1 & gnt1;
        sel_rw    = sel ? rw1 : rw0;
        sel_lock  = sel ? lock1 : lock0;
        sel_a     = sel ? a1 : a0;
        sel_wd    = sel ? wd1 : wd0;
        // A new owner starts its burst count from zero.
        bcnt_base = (sel != own) ? '0 : bcnt;
        bcnt_inc  = {1'b0, bcnt_base} + (BW + 1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            men     <= 1'b0;
            rw      <= 1'b1;
            da      <= '0;
            dout    <= '0;
            mid     <= 1'b0;
            pri     <= 1'b0;
            own     <= 1'b0;
            bcnt    <= '0;
            pend_v  <= 1'b0;
            pend_id <= 1'b0;
            rv0     <= 1'b0;
            rv1     <= 1'b0;
            rd0     <= '0;
            rd1     <= '0;
        end else begin
            men <= acc;
            if (acc) begin
                da   <= sel_a;
                dout <= sel_wd;
                rw   <= sel_rw;
                mid  <= sel;
                own  <= sel;
                if (sel_lock && (bcnt_inc < MAXB)) begin
                    pri  <= sel;
                    bcnt <= bcnt_inc[BW-1:0];
                end else begin
                    pri  <= ~sel;
                    bcnt <= '0;
                end
            end
            // DI answers the read on the port one cycle later.
            pend_v  <= men & rw;
            pend_id <= mid;
            rv0     <= pend_v & ~pend_id;
            rv1     <= pend_v & pend_id;
            if (pend_v && !pend_id) rd0 <= din;
            if (pend_v && pend_id) rd1 <= din;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected commands and read returns are
// queued by the stimulus and consumed by a monitor watching MEN and RV.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, rw0, rw1, lock0, lock1;
    logic [15:0] a0, a1, wd0, wd1;
    logic        gnt0, gnt1, rv0, rv1, men, rw;
    logic [15:0] rd0, rd1, da, dout, din;

    dmem_arbiter #(
        .AW(16),
        .DW(16),
        .MAXBURST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .lock0(lock0), .lock1(lock1),
        .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rd0(rd0), .rd1(rd1), .rv0(rv0), .rv1(rv1),
        .men(men), .rw(rw), .da(da), .dout(dout), .din(din)
    );

    typedef struct packed {
        logic        rw;
        logic [15:0] a;
        logic [15:0] d;
    } cmd_t;

    typedef struct packed {
        logic        m;
        logic [15:0] d;
    } rdx_t;

    cmd_t cmd_q[$];
    rdx_t rd_q[$];
    cmd_t mon_c;
    rdx_t mon_r;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:15];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous DMEM: read data appears the cycle after the command.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
            mem[0] <= 16'h0005;
            mem[1] <= 16'h0011;
            mem[2] <= 16'h0022;
            din    <= 16'h0000;
        end else if (men) begin
            if (!rw) mem[da[3:0]] <= dout;
            din <= mem[da[3:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (men) begin
            if (cmd_q.size() == 0) begin
                check("unexpected_cmd", {31'd0, men}, 32'd0);
            end else begin
                mon_c = cmd_q.pop_front();
                check("cmd_rw", {31'd0, rw}, {31'd0, mon_c.rw});
                check("cmd_da", {16'd0, da}, {16'd0, mon_c.a});
                check("cmd_do", {16'd0, dout}, {16'd0, mon_c.d});
            end
        end
        if (rv0 || rv1) begin
            if (rd_q.size() == 0) begin
                check("unexpected_rv", {30'd0, rv1, rv0}, 32'd0);
            end else begin
                mon_r = rd_q.pop_front();
                check("rv_route", {30'd0, rv1, rv0}, mon_r.m ? 32'd2 : 32'd1);
                check("rd_data", {16'd0, mon_r.m ? rd1 : rd0}, {16'd0, mon_r.d});
            end
        end
    end

    task automatic access(input logic m, input logic r, input logic [15:0] a,
                          input logic [15:0] wd, input logic want_rv,
                          input logic [15:0] exp_d);
        logic ok;
        cmd_q.push_back('{r, a, wd});
        if (want_rv) rd_q.push_back('{m, exp_d});
        if (m) begin
            req1 = 1'b1; rw1 = r; a1 = a; wd1 = wd;
        end else begin
            req0 = 1'b1; rw0 = r; a0 = a; wd0 = wd;
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = m ? gnt1 : gnt0;
            @(posedge clk);
            #1;
        end
        if (!ok) check("access_timeout", 32'd0, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_men"}, {31'd0, men}, 32'd0);
        check({tag, "_rw"}, {31'd0, rw}, 32'd1);
        check({tag, "_da"}, {16'd0, da}, 32'd0);
        check({tag, "_do"}, {16'd0, dout}, 32'd0);
        check({tag, "_rv"}, {30'd0, rv1, rv0}, 32'd0);
        check({tag, "_rd0"}, {16'd0, rd0}, 32'd0);
        check({tag, "_rd1"}, {16'd0, rd1}, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (cmd_q.size() != 0 || rd_q.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_cmd", cmd_q.size(), 32'd0);
        check("drain_rd", rd_q.size(), 32'd0);
    endtask

    logic [5:0] order;

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b1; rw1 = 1'b1;
        lock0 = 1'b0; lock1 = 1'b0;
        a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;

        // Grant is combinational even in reset, but nothing is accepted.
        #12;
        req1 = 1'b1;
        #1;
        check("rst_gnt1", {31'd0, gnt1}, 32'd1);
        check("rst_gnt0", {31'd0, gnt0}, 32'd0);
        reset_vals("rst");
        @(posedge clk);
        #1;
        check("rst_no_accept", {31'd0, men}, 32'd0);
        req1 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_men", {31'd0, men}, 32'd0);
        check("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        @(posedge clk);
        #1;

        // Single read by M0, then M1 write/read-back.
        access(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0005);
        access(1'b1, 1'b0, 16'h0000, 16'h0004, 1'b0, 16'h0000);
        access(1'b1, 1'b1, 16'h0000, 16'h0004, 1'b1, 16'h0004);
        drain();

        // Unlocked contention: strict alternation starting with M0.
        order = 6'b101010;
        for (int i = 0; i < 6; i++) begin
            cmd_q.push_back('{1'b1, order[i] ? 16'h0002 : 16'h0001, 16'h0000});
            rd_q.push_back('{order[i], order[i] ? 16'h0022 : 16'h0011});
        end
        req0 = 1'b1; req1 = 1'b1; rw0 = 1'b1; rw1 = 1'b1;
        a0 = 16'h0001; a1 = 16'h0002; wd0 = '0; wd1 = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("cont_gnt0", {31'd0, gnt0}, {31'd0, ~order[i]});
            check("cont_gnt1", {31'd0, gnt1}, {31'd0, order[i]});
            @(posedge clk);
            #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        drain();

        // Locked burst by M0: four grants, then M1 once, then M0 again.
        order = 6'b010000;
        for (int i = 0; i < 6; i++) begin
            cmd_q.push_back('{1'b0, order[i] ? 16'h0004 : 16'h0003,
                              order[i] ? 16'h00b1 : 16'h00a0});
        end
        req0 = 1'b1; req1 = 1'b1; rw0 = 1'b0; rw1 = 1'b0; lock0 = 1'b1;
        a0 = 16'h0003; a1 = 16'h0004; wd0 = 16'h00a0; wd1 = 16'h00b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("burst_gnt0", {31'd0, gnt0}, {31'd0, ~order[i]});
            check("burst_gnt1", {31'd0, gnt1}, {31'd0, order[i]});
            @(posedge clk);
            #1;
        end
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        drain();

        // Reset one cycle after a read is accepted: its RV must never appear.
        access(1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        reset_vals("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_rv", {30'd0, rv1, rv0}, 32'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter sharing the single data-memory port (address, write data, read data, RW) between the CPU core (master 0) and a second requester such as the memory loader or debug host (master 1). It accepts at most one access per cycle, registers the winning command onto the memory port, and returns read data to the issuing master with a valid strobe. It supports bounded locked bursts. The block sits between the masters and DMEM; the top level bridges DO/DI onto the bidirectional DD bus.

## Interface
- AW, 16, address width
- DW, 16, data width
- MAXBURST, 4, max consecutive locked accesses by one master (≥1)

- CK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- REQ0 / REQ1  in  1  access request, master 0 / 1
- RW0 / RW1  in  1  1 = read, 0 = write
- LOCK0 / LOCK1  in  1  request to retain ownership for the next access
- A0 / A1  in  AW  address
- WD0 / WD1  in  DW  write data
- GNT0 / GNT1  out  1  combinational grant; access accepted when REQx & GNTx at a rising CK
- RD0 / RD1  out  DW  read data
- RV0 / RV1  out  1  read data valid, one-cycle pulse
- MEN  out  1  memory command valid (registered)
- RW  out  1  memory direction, 1 = read (registered)
- DA  out  AW  memory address (registered)
- DO  out  DW  memory write data (registered)
- DI  in  DW  memory read data, valid one cycle after a read command on MEN/RW/DA

## Operation
- State: priority pointer PRI (0/1), owner register OWN, burst counter BCNT (0..MAXBURST), read-pending registers PEND (valid + master id).
- Grant (combinational): at most one GNT high. Only one REQ high → that master is granted. Both high → the master selected by PRI is granted. No REQ → no GNT.
- On acceptance by Mx: DA←Ax, DO←WDx, RW←RWx, MEN←1 at the same edge. No acceptance → MEN←0; DA/DO/RW hold their values.
- PRI update on acceptance by Mx:
  - LOCKx=1 and BCNT+1 < MAXBURST → PRI←x, BCNT←BCNT+1 (BCNT counts locked accesses by OWN).
  - Otherwise → PRI←other, BCNT←0.
  - Acceptance by a master ≠ OWN resets BCNT to 0 before the rule above; OWN←x.
- A lock only matters under contention; a lone requester is always granted, independent of BCNT.
- Read return: when a read command is on MEN (RW=1), PEND records the master; next cycle RDx←DI, RVx←1 for that master only. Writes produce no RV.
- RDx holds its value until the next read return to the same master.
- Masters must hold REQx, RWx, Ax, WDx, LOCKx stable until accepted.

## Timing
- Reset (RST low, asynchronous): MEN=0, RW=1, DA=0, DO=0, RV0=RV1=0, RD0=RD1=0, PRI=0, OWN=0, BCNT=0, PEND cleared. GNT follows REQ/PRI combinationally, even during reset. Accesses are not accepted while RST is low.
- Accept at edge N → command on the memory port during cycle N..N+1 → DI sampled at edge N+2 → RVx high for the cycle after edge N+2. Read latency is 2 cycles from acceptance.
- Throughput is one access per cycle. Back-to-back reads pipeline, so RV can be high every cycle.
- Simultaneous REQ0 and REQ1 with no locks → strict alternation 0,1,0,1,…
- Reset mid-read: the pending RV is dropped and no RV is asserted after RST rises.
- MAXBURST=1: locks are ineffective and behaviour is pure round-robin.

## Test plan
- Reset: with RST low, all outputs hold the listed reset values. After RST rises, with no REQ, MEN stays 0 and GNT0=GNT1=0.
- Single read: DMEM[0]=5; M0 reads A0=0 accepted at edge N → MEN=1, RW=1, DA=0 after N; RV0=1 and RD0=5 after N+2; RV1 stays 0.
- Write then read-back: M1 writes WD1=0x0004 to A1=0, then reads address 0 → the memory port shows RW=0, DO=4, then RW=1; RD1=4 with RV1.
- Contention: REQ0 and REQ1 both held high for 6 cycles, no lock → grant order 0,1,0,1,0,1. RD/RV are routed to the correct master.
- Locked burst: MAXBURST=4, both requesting, LOCK0=1 → M0 is granted 4 consecutive times, then M1 once, then M0 again.
- Reset mid-read: M0 read accepted, RST pulsed low one cycle later → no RV0 is asserted, and all outputs return to reset values.
